bin_to_bcd_disp: RTL and testbench
==================================

Name: bin_to_bcd_disp

Overview:
- Sequential binary-to-BCD converter; the output-side counterpart of the switch/key BCD entry path.
- Takes a 10-bit binary result, such as a temperature difference or computed reading, and produces ones/tens/hundreds digits plus a sign code.
- Outputs feed the existing seven_seg instances directly.
- Uses a shift-add-3 (double-dabble) FSM, one bit per clock, with a start/busy/done handshake.

Parameters:
- SIGNED, 1, 1 = din is two's complement (-512..511); 0 = din is unsigned (0..1023).
- NEG_CODE, 4'hA, 4-bit code driven on sign for negative values (seven_seg minus glyph).
- OFF_CODE, 4'hF, 4-bit code for a blank digit (matches `OFF).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  asynchronous, active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- din  in  10  binary value; sampled on the accepting start edge.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when new digits are valid.
- ones_value  out  4  BCD ones digit.
- tens_value  out  4  BCD tens digit.
- huns_value  out  4  BCD hundreds digit.
- sign  out  4  NEG_CODE if the result is negative, else OFF_CODE.
- ovf  out  1  magnitude > 999; digits saturated.

Behaviour:
- Reset (rst low, async): state IDLE, busy=0, done=0, all digits 0, sign=OFF_CODE, ovf=0, internal shift and BCD registers cleared.
- States and transitions:
  - IDLE: on a clk edge with start=1, latch din, compute magnitude, latch the sign flag, clear the BCD scratch, set bit count = 0, go to SHIFT, busy=1.
  - SHIFT: each edge, add 3 to any scratch BCD nibble >= 5, then shift the {BCD, magnitude} register left by 1 and increment the count. After the 10th shift, go to DONE.
  - DONE: one edge to register outputs, pulse done=1, drop busy, return to IDLE.
- Latency: start accepted at edge k; busy=1 after k; outputs and done=1 valid after edge k+11. done is deasserted after edge k+12.
- Magnitude:
  - SIGNED=1 and din[9]=1: magnitude = -din in 10 bits. -512 gives 512, which is correct.
  - SIGNED=0: magnitude = din, sign is always OFF_CODE.
- Zero is never negative: the sign code is OFF_CODE even if the input was 0.
- Overflow: if magnitude > 999 (only possible with SIGNED=0), registered digits are 9/9/9 and ovf=1; otherwise ovf=0.
- ovf and digits update only on the DONE edge. Between conversions, outputs hold their last values (no flicker on the display).
- start while busy is ignored; no queueing. start held high continuously gives back-to-back conversions: a new accept occurs in the IDLE cycle following DONE.
- din changes after the accepting edge have no effect on the current conversion.
- Reset mid-conversion aborts immediately to the reset values; no done pulse is produced.
- Digits are always legal BCD (0-9), except for the blank substitution below.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- When defined, on the DONE edge:
  - huns_value = OFF_CODE if the hundreds digit is 0.
  - tens_value = OFF_CODE if both hundreds and tens are 0.
  - ones_value is never blanked.
  - sign is unaffected.
- When undefined, all three digits are always driven as numeric BCD (e.g. 007).

Test Plan:
- Reset check: hold rst=0 mid-conversion (din=10'd345, start at cycle 0, reset at cycle 5) -> busy=0, done never pulses, digits 0/0/0, sign=OFF_CODE.
- Signed positive: SIGNED=1, din=10'd345, start one cycle -> exactly 11 cycles later done=1 for one cycle; huns/tens/ones=3/4/5, sign=4'hF, ovf=0.
- Signed negative: din=10'h2EF (-273) -> digits 2/7/3, sign=4'hA. Also din=10'h200 (-512) -> 5/1/2, sign=4'hA.
- Unsigned overflow: SIGNED=0, din=10'd1000 -> 9/9/9, ovf=1. Then din=10'd999 -> 9/9/9, ovf=0. Then din=0 -> 0/0/0, sign=4'hF.
- Handshake: pulse start again 3 cycles into busy with din=10'd12 -> ignored, result still from the first din. With start held high for 30 cycles -> done pulses every 12 cycles.
- With LEADING_ZERO_BLANK_EN: din=10'd7 -> huns=4'hF, tens=4'hF, ones=7. din=10'd40 -> huns=4'hF, tens=4, ones=0. din=0 -> ones=0.

Source files
------------

// File: rtl/bin_to_bcd_disp.sv
// Sequential 10-bit binary to 3-digit BCD converter (double-dabble, one bit per clock) driving seven_seg digits.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits with OFF_CODE.
module bin_to_bcd_disp #(
    parameter bit         SIGNED   = 1'b1,
    parameter logic [3:0] NEG_CODE = 4'hA,
    parameter logic [3:0] OFF_CODE = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] din,
    output logic       busy,
    output logic       done,
    output logic [3:0] ones_value,
    output logic [3:0] tens_value,
    output logic [3:0] huns_value,
    output logic [3:0] sign,
    output logic       ovf
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t      state_q;
    // {thousands[1:0], hundreds, tens, ones, magnitude[9:0]}
    logic [23:0] sr_q;
    logic [3:0]  cnt_q;
    logic        neg_q;
    logic        busy_q, done_q, ovf_q;
    logic [3:0]  ones_q, tens_q, huns_q, sign_q;

    logic [9:0]  mag;
    logic [23:0] sr_adj;
    logic [3:0]  ones_d, tens_d, huns_d;
    logic        ovf_d;

    always_comb begin
        mag = (SIGNED && din[9]) ? (~din + 10'd1) : din;
    end

    // Add-3 correction on the three low BCD nibbles; thousands never exceeds 1.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < 3; i++) begin
            if (sr_q[10 + 4*i +: 4] >= 4'd5)
                sr_adj[10 + 4*i +: 4] = sr_q[10 + 4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        ovf_d  = |sr_q[23:22];
        huns_d = sr_q[21:18];
        tens_d = sr_q[17:14];
        ones_d = sr_q[13:10];
        if (ovf_d) begin
            huns_d = 4'd9;
            tens_d = 4'd9;
            ones_d = 4'd9;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (huns_d == 4'd0) begin
            huns_d = OFF_CODE;
            if (tens_d == 4'd0)
                tens_d = OFF_CODE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            huns_q  <= 4'd0;
            sign_q  <= OFF_CODE;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sr_q    <= {14'd0, mag};
                        neg_q   <= SIGNED && din[9];
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sr_q  <= sr_adj << 1;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd9)
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    ones_q  <= ones_d;
                    tens_q  <= tens_d;
                    huns_q  <= huns_d;
                    ovf_q   <= ovf_d;
                    // A negative input is always non-zero, so zero never shows a minus.
                    sign_q  <= neg_q ? NEG_CODE : OFF_CODE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ones_value = ones_q;
    assign tens_value = tens_q;
    assign huns_value = huns_q;
    assign sign       = sign_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_disp.sv
// Directed bench for bin_to_bcd_disp: one signed and one unsigned instance on a shared clock/reset.
module tb_bin_to_bcd_disp;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s, start_u;
    logic [9:0] din_s, din_u;
    logic       busy_s, done_s, ovf_s, busy_u, done_u, ovf_u;
    logic [3:0] ones_s, tens_s, huns_s, sign_s;
    logic [3:0] ones_u, tens_u, huns_u, sign_u;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bin_to_bcd_disp #(.SIGNED(1'b1), .NEG_CODE(4'hA), .OFF_CODE(4'hF)) u_s (
        .clk(clk), .rst(rst), .start(start_s), .din(din_s),
        .busy(busy_s), .done(done_s),
        .ones_value(ones_s), .tens_value(tens_s), .huns_value(huns_s),
        .sign(sign_s), .ovf(ovf_s)
    );

    bin_to_bcd_disp #(.SIGNED(1'b0), .NEG_CODE(4'hA), .OFF_CODE(4'hF)) u_u (
        .clk(clk), .rst(rst), .start(start_u), .din(din_u),
        .busy(busy_u), .done(done_u),
        .ones_value(ones_u), .tens_value(tens_u), .huns_value(huns_u),
        .sign(sign_u), .ovf(ovf_u)
    );

    // Expected {huns, tens, ones} after optional leading-zero blanking.
    function automatic logic [11:0] expd(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        logic [3:0] hh, tt;
        hh = h;
        tt = t;
`ifdef LEADING_ZERO_BLANK_EN
        if (h == 4'd0) begin
            hh = 4'hF;
            if (t == 4'd0) tt = 4'hF;
        end
`endif
        return {hh, tt, o};
    endfunction

    function automatic logic [16:0] obs_s();
        return {huns_s, tens_s, ones_s, sign_s, ovf_s};
    endfunction

    function automatic logic [16:0] obs_u();
        return {huns_u, tens_u, ones_u, sign_u, ovf_u};
    endfunction

    // Pulse start for one cycle and count falling edges until done (bounded at 40).
    task automatic run_conv(input bit uns, input logic [9:0] d, output int n);
        @(negedge clk);
        if (uns) begin start_u = 1'b1; din_u = d; end
        else     begin start_s = 1'b1; din_s = d; end
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin start_s = 1'b0; start_u = 1'b0; end
            if ((uns ? done_u : done_s) === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start_s = 1'b0; start_u = 1'b0; din_s = '0; din_u = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_s, done_s, busy_u, done_u} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=0000", {busy_s, done_s, busy_u, done_u});
        end
        checks++;
        if (obs_s() !== {12'h000, 4'hF, 1'b0}) begin
            errors++; $display("FAIL reset_digits got=%h exp=%h", obs_s(), {12'h000, 4'hF, 1'b0});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_signed_pos();
        int n;
        run_conv(1'b0, 10'd345, n);
        checks++;
        if (n !== 12) begin errors++; $display("FAIL pos_latency got=%0d exp=12", n); end
        checks++;
        if (obs_s() !== {expd(4'd3, 4'd4, 4'd5), 4'hF, 1'b0}) begin
            errors++; $display("FAIL pos_digits got=%h exp=%h", obs_s(), {expd(4'd3, 4'd4, 4'd5), 4'hF, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({done_s, busy_s} !== 2'b00) begin
            errors++; $display("FAIL pos_done_width got=%b exp=00", {done_s, busy_s});
        end
        repeat (5) @(negedge clk);
        checks++;
        if (obs_s() !== {expd(4'd3, 4'd4, 4'd5), 4'hF, 1'b0}) begin
            errors++; $display("FAIL pos_hold got=%h", obs_s());
        end
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        @(negedge clk);
        start_s = 1'b1; din_s = 10'd345;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 1) start_s = 1'b0;
            if (c == 5) rst = 1'b0;
            if (c == 8) rst = 1'b1;
            if (done_s === 1'b1) pulses++;
            if (c == 6) begin
                checks++;
                if (busy_s !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy_s); end
                checks++;
                if (obs_s() !== {12'h000, 4'hF, 1'b0}) begin
                    errors++; $display("FAIL abort_digits got=%h exp=%h", obs_s(), {12'h000, 4'hF, 1'b0});
                end
            end
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    endtask

    task automatic test_signed_neg();
        int n;
        run_conv(1'b0, 10'h2EF, n);
        checks++;
        if (obs_s() !== {expd(4'd2, 4'd7, 4'd3), 4'hA, 1'b0}) begin
            errors++; $display("FAIL neg273 got=%h exp=%h", obs_s(), {expd(4'd2, 4'd7, 4'd3), 4'hA, 1'b0});
        end
        run_conv(1'b0, 10'h200, n);
        checks++;
        if (obs_s() !== {expd(4'd5, 4'd1, 4'd2), 4'hA, 1'b0}) begin
            errors++; $display("FAIL neg512 got=%h exp=%h", obs_s(), {expd(4'd5, 4'd1, 4'd2), 4'hA, 1'b0});
        end
        run_conv(1'b0, 10'd0, n);
        checks++;
        if (obs_s() !== {expd(4'd0, 4'd0, 4'd0), 4'hF, 1'b0}) begin
            errors++; $display("FAIL szero got=%h exp=%h", obs_s(), {expd(4'd0, 4'd0, 4'd0), 4'hF, 1'b0});
        end
    endtask

    task automatic test_unsigned_ovf();
        int n;
        run_conv(1'b1, 10'd1000, n);
        checks++;
        if (n !== 12) begin errors++; $display("FAIL u_latency got=%0d exp=12", n); end
        checks++;
        if (obs_u() !== {12'h999, 4'hF, 1'b1}) begin
            errors++; $display("FAIL u1000 got=%h exp=%h", obs_u(), {12'h999, 4'hF, 1'b1});
        end
        run_conv(1'b1, 10'd1023, n);
        checks++;
        if (obs_u() !== {12'h999, 4'hF, 1'b1}) begin
            errors++; $display("FAIL u1023 got=%h exp=%h", obs_u(), {12'h999, 4'hF, 1'b1});
        end
        run_conv(1'b1, 10'd999, n);
        checks++;
        if (obs_u() !== {12'h999, 4'hF, 1'b0}) begin
            errors++; $display("FAIL u999 got=%h exp=%h", obs_u(), {12'h999, 4'hF, 1'b0});
        end
        run_conv(1'b1, 10'd0, n);
        checks++;
        if (obs_u() !== {expd(4'd0, 4'd0, 4'd0), 4'hF, 1'b0}) begin
            errors++; $display("FAIL u0 got=%h exp=%h", obs_u(), {expd(4'd0, 4'd0, 4'd0), 4'hF, 1'b0});
        end
        run_conv(1'b1, 10'd600, n);
        checks++;
        if (obs_u() !== {expd(4'd6, 4'd0, 4'd0), 4'hF, 1'b0}) begin
            errors++; $display("FAIL u600 got=%h exp=%h", obs_u(), {expd(4'd6, 4'd0, 4'd0), 4'hF, 1'b0});
        end
    endtask

    task automatic test_blank();
        int n;
        run_conv(1'b1, 10'd7, n);
        checks++;
        if (obs_u() !== {expd(4'd0, 4'd0, 4'd7), 4'hF, 1'b0}) begin
            errors++; $display("FAIL blank7 got=%h exp=%h", obs_u(), {expd(4'd0, 4'd0, 4'd7), 4'hF, 1'b0});
        end
        run_conv(1'b1, 10'd40, n);
        checks++;
        if (obs_u() !== {expd(4'd0, 4'd4, 4'd0), 4'hF, 1'b0}) begin
            errors++; $display("FAIL blank40 got=%h exp=%h", obs_u(), {expd(4'd0, 4'd4, 4'd0), 4'hF, 1'b0});
        end
    endtask

    task automatic test_handshake();
        int n = 0;
        int extra = 0;
        @(negedge clk);
        start_s = 1'b1; din_s = 10'd88;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start_s = 1'b0;
                checks++;
                if (busy_s !== 1'b1) begin errors++; $display("FAIL hs_busy got=%b exp=1", busy_s); end
            end
            if (n == 2) din_s = 10'd999;
            if (n == 3) begin start_s = 1'b1; din_s = 10'd12; end
            if (n == 4) start_s = 1'b0;
            if (done_s === 1'b1) break;
        end
        checks++;
        if (n !== 12) begin errors++; $display("FAIL hs_latency got=%0d exp=12", n); end
        checks++;
        if (obs_s() !== {expd(4'd0, 4'd8, 4'd8), 4'hF, 1'b0}) begin
            errors++; $display("FAIL hs_digits got=%h exp=%h", obs_s(), {expd(4'd0, 4'd8, 4'd8), 4'hF, 1'b0});
        end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done_s === 1'b1 || busy_s === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL hs_no_queue got=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        int first = 0;
        int second = 0;
        @(negedge clk);
        start_s = 1'b1; din_s = 10'd12;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done_s === 1'b1) begin
                cnt++;
                if (cnt == 1) first = c;
                if (cnt == 2) second = c;
            end
        end
        start_s = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (cnt !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", cnt); end
        checks++;
        if (first !== 12 || second !== 24) begin
            errors++; $display("FAIL b2b_spacing got=%0d,%0d exp=12,24", first, second);
        end
        checks++;
        if ({busy_s, obs_s()} !== {1'b0, expd(4'd0, 4'd1, 4'd2), 4'hF, 1'b0}) begin
            errors++; $display("FAIL b2b_digits got=%h", {busy_s, obs_s()});
        end
    endtask

    initial begin
        test_reset();
        test_signed_pos();
        test_reset_abort();
        test_signed_neg();
        test_unsigned_ovf();
        test_blank();
        test_handshake();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
